// File: rtl/updi_uart_rx.sv
// UPDI receive path: 8E2 UART deserializer with break detection and sticky
// parity / frame / overflow error flags feeding the programmer's RX FIFO.
module updi_uart_rx #(
    parameter int UART_CLK_DIV = 1736
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_en,
    output logic [7:0] fifo_data,
    output logic       fifo_wr_en,
    input  logic       fifo_full,
    output logic       break_det,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overflow,
    output logic       rx_error,
    input  logic       err_clr,
    output logic       busy
);

    localparam int CW = $clog2(UART_CLK_DIV);
    localparam logic [CW-1:0] HALF_LD = CW'(UART_CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LD  = CW'(UART_CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    // Even parity over data plus received parity bit; 1 means mismatch.
    function automatic logic parity_err(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    state_t        state_r, state_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [2:0]    idx_r, idx_nx;
    logic [7:0]    shift_r, shift_nx;
    logic          par_r, par_nx;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic          fall_s, tick_s;
    logic          wr_s, brk_s, set_par_s, set_frm_s, set_ovf_s;
    logic          err_par_nx, err_frm_nx, err_ovf_nx;
    logic [7:0]    fifo_data_r;
    logic          wr_r, brk_r, err_par_r, err_frm_r, err_ovf_r, rx_error_r, busy_r;

    assign fall_s = rx_prev_r & ~rx_sync_r;
    assign tick_s = (cnt_r == '0);

    // Two-flop synchronizer plus one history flop for falling-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= rx;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Frame state register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            idx_r   <= 3'd0;
            shift_r <= 8'h00;
            par_r   <= 1'b0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
            idx_r   <= idx_nx;
            shift_r <= shift_nx;
            par_r   <= par_nx;
        end
    end

    // Next-state, bit timing and frame-outcome events.
    always_comb begin
        state_nx  = state_r;
        cnt_nx    = cnt_r;
        idx_nx    = idx_r;
        shift_nx  = shift_r;
        par_nx    = par_r;
        wr_s      = 1'b0;
        brk_s     = 1'b0;
        set_par_s = 1'b0;
        set_frm_s = 1'b0;
        set_ovf_s = 1'b0;
        if ((state_r != IDLE) && !rx_en) begin
            // Abort silently: the PHY owns the line.
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            if (state_r != IDLE) begin
                cnt_nx = tick_s ? BIT_LD : (cnt_r - CW'(1));
            end else begin
                cnt_nx = '0;
            end
            case (state_r)
                IDLE: begin
                    if (rx_en && fall_s) begin
                        state_nx = START;
                        cnt_nx   = HALF_LD;
                        idx_nx   = 3'd0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
                START: begin
                    if (tick_s) begin
                        state_nx = rx_sync_r ? IDLE : DATA;
                    end else begin
                        state_nx = START;
                    end
                end
                DATA: begin
                    if (tick_s) begin
                        shift_nx = {rx_sync_r, shift_r[7:1]};
                        idx_nx   = idx_r + 3'd1;
                        state_nx = (idx_r == 3'd7) ? PARITY : DATA;
                    end else begin
                        state_nx = DATA;
                    end
                end
                PARITY: begin
                    if (tick_s) begin
                        par_nx   = rx_sync_r;
                        state_nx = STOP1;
                    end else begin
                        state_nx = PARITY;
                    end
                end
                STOP1: begin
                    if (tick_s) begin
                        if (rx_sync_r) begin
                            state_nx = STOP2;
                        end else begin
                            state_nx = IDLE;
                            if ((shift_r == 8'h00) && !par_r) begin
                                brk_s = 1'b1;
                            end else begin
                                set_frm_s = 1'b1;
                            end
                        end
                    end else begin
                        state_nx = STOP1;
                    end
                end
                STOP2: begin
                    if (tick_s) begin
                        state_nx = IDLE;
                        if (!rx_sync_r) begin
                            set_frm_s = 1'b1;
                        end else if (parity_err(shift_r, par_r)) begin
                            set_par_s = 1'b1;
                        end else if (fifo_full) begin
                            set_ovf_s = 1'b1;
                        end else begin
                            wr_s = 1'b1;
                        end
                    end else begin
                        state_nx = STOP2;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // Sticky flag update: a set event wins over a simultaneous clear.
    always_comb begin
        err_par_nx = set_par_s | (err_par_r & ~err_clr);
        err_frm_nx = set_frm_s | (err_frm_r & ~err_clr);
        err_ovf_nx = set_ovf_s | (err_ovf_r & ~err_clr);
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifo_data_r <= 8'h00;
            wr_r        <= 1'b0;
            brk_r       <= 1'b0;
            err_par_r   <= 1'b0;
            err_frm_r   <= 1'b0;
            err_ovf_r   <= 1'b0;
            rx_error_r  <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            if (wr_s) begin
                fifo_data_r <= shift_r;
            end
            wr_r       <= wr_s;
            brk_r      <= brk_s;
            err_par_r  <= err_par_nx;
            err_frm_r  <= err_frm_nx;
            err_ovf_r  <= err_ovf_nx;
            rx_error_r <= err_par_nx | err_frm_nx | err_ovf_nx;
            busy_r     <= (state_nx != IDLE);
        end
    end

    assign fifo_data    = fifo_data_r;
    assign fifo_wr_en   = wr_r;
    assign break_det    = brk_r;
    assign err_parity   = err_par_r;
    assign err_frame    = err_frm_r;
    assign err_overflow = err_ovf_r;
    assign rx_error     = rx_error_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_updi_uart_rx.sv
// Self-checking bench for updi_uart_rx at 16 clocks per bit: a table of
// whole frames plus directed sequences for timing, glitch, abort and reset.
module tb_updi_uart_rx;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_en = 1'b1;
    logic       fifo_full = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] fifo_data;
    logic       fifo_wr_en, break_det, err_parity, err_frame, err_overflow, rx_error, busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int brk_cnt = 0;
    int wr_cyc = -1;
    logic [7:0] wr_last = 8'h00;

    updi_uart_rx #(.UART_CLK_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .rx(rx), .rx_en(rx_en),
        .fifo_data(fifo_data), .fifo_wr_en(fifo_wr_en), .fifo_full(fifo_full),
        .break_det(break_det), .err_parity(err_parity), .err_frame(err_frame),
        .err_overflow(err_overflow), .rx_error(rx_error), .err_clr(err_clr),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt  <= wr_cnt + 1;
            wr_cyc  <= cyc;
            wr_last <= fifo_data;
        end
        if (break_det) brk_cnt <= brk_cnt + 1;
    end

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop1;
        logic       stop2;
        logic       full;
        int         exp_wr;
        int         exp_brk;
        logic [2:0] exp_flags;  // {overflow, frame, parity}
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] frame(input logic [7:0] d, input logic p,
                                          input logic s1, input logic s2);
        return {s2, s1, p, d, 1'b0};
    endfunction

    // Caller is aligned to posedge+1; each bit lasts DIV clocks.
    task automatic send_bits(input logic [11:0] bits, input int first, input int last);
        for (int i = first; i <= last; i++) begin
            rx = bits[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    initial begin
        int wr0, brk0, c0;
        logic [7:0] hold;

        vecs[0]  = '{8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 3'b000};
        vecs[1]  = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'b001};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 3'b000};
        vecs[3]  = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 3'b000};
        vecs[4]  = '{8'hA3, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 3'b100};
        vecs[5]  = '{8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 3'b010};
        vecs[6]  = '{8'h81, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 3'b010};
        vecs[7]  = '{8'h80, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0, 3'b000};
        vecs[8]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 3'b000};
        vecs[9]  = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'b001};
        vecs[10] = '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 3'b010};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(fifo_data), 32'h00);
        check("reset_wr", 32'(fifo_wr_en), 32'h0);
        check("reset_flags", 32'({break_det, err_parity, err_frame, err_overflow, rx_error}), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        idle(2 * DIV);

        // 0x55 with exact write latency
        wr0 = wr_cnt;
        c0 = cyc;
        send_bits(frame(8'h55, 1'b0, 1'b1, 1'b1), 0, 11);
        idle(2 * DIV);
        check("lat_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("lat_cycle", 32'(wr_cyc - c0), 32'd187);
        check("lat_data", 32'(wr_last), 32'h55);
        check("lat_flags", 32'({err_parity, err_frame, err_overflow, rx_error}), 32'h0);
        hold = 8'h55;

        // Table of whole frames
        for (int v = 0; v < 11; v++) begin
            pulse_clr();
            fifo_full = vecs[v].full;
            wr0 = wr_cnt;
            brk0 = brk_cnt;
            send_bits(frame(vecs[v].data, vecs[v].par, vecs[v].stop1, vecs[v].stop2), 0, 11);
            idle(2 * DIV);
            fifo_full = 1'b0;
            if (vecs[v].exp_wr != 0) hold = vecs[v].data;
            check($sformatf("vec%0d_wr", v), 32'(wr_cnt - wr0), 32'(vecs[v].exp_wr));
            check($sformatf("vec%0d_brk", v), 32'(brk_cnt - brk0), 32'(vecs[v].exp_brk));
            check($sformatf("vec%0d_data", v), 32'(fifo_data), 32'(hold));
            check($sformatf("vec%0d_flags", v), 32'({err_overflow, err_frame, err_parity}),
                  32'(vecs[v].exp_flags));
            check($sformatf("vec%0d_rxerr", v), 32'(rx_error), 32'(|vecs[v].exp_flags));
            check($sformatf("vec%0d_busy", v), 32'(busy), 32'h0);
        end

        // Parity error then clear
        pulse_clr();
        send_bits(frame(8'h01, 1'b0, 1'b1, 1'b1), 0, 11);
        idle(DIV);
        check("par_set", 32'({err_parity, rx_error}), 32'h3);
        pulse_clr();
        check("par_clr", 32'({err_parity, rx_error}), 32'h0);

        // Short low glitch
        wr0 = wr_cnt;
        brk0 = brk_cnt;
        rx = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_hi", 32'(busy), 32'h1);
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_lo", 32'(busy), 32'h0);
        @(posedge clk);
        #1;
        idle(2 * DIV);
        check("glitch_quiet", 32'({wr_cnt - wr0, brk_cnt - brk0}), 32'h0);
        check("glitch_flags", 32'(rx_error), 32'h0);

        // rx_en dropped mid-frame
        wr0 = wr_cnt;
        send_bits(frame(8'hFF, 1'b0, 1'b1, 1'b1), 0, 2);
        rx_en = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(busy), 32'h0);
        send_bits(frame(8'hFF, 1'b0, 1'b1, 1'b1), 3, 11);
        idle(DIV);
        rx_en = 1'b1;
        idle(DIV);
        check("abort_nowr", 32'(wr_cnt - wr0), 32'h0);
        check("abort_flags", 32'(rx_error), 32'h0);

        // Reset during data bit 4, then a clean frame
        wr0 = wr_cnt;
        send_bits(frame(8'hFF, 1'b0, 1'b1, 1'b1), 0, 4);
        rx = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst_outputs", 32'({fifo_data, fifo_wr_en, break_det, rx_error, busy}), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        idle(2 * DIV);
        send_bits(frame(8'h81, 1'b0, 1'b1, 1'b1), 0, 11);
        idle(2 * DIV);
        check("rst_wr_count", 32'(wr_cnt - wr0), 32'd1);
        check("rst_data", 32'(fifo_data), 32'h81);
        check("rst_flags", 32'(rx_error), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
